// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed-priority arbitration,
// packet locking and a registered output stage.
//
// state  | meaning
// IDLE   | no packet in progress; arbiter picks a grant each cycle the register can load
// LOCKED | mid-packet; only lock_ch may be accepted until its last beat is captured
module stream_mux_rr #(
  parameter int N_CH = 4,
  parameter int W = 8,
  parameter int RR = 1,
  localparam int CW = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [CW-1:0]     out_ch,
  input  logic              out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ptr;
  logic [CW-1:0] lock_ch, lock_nxt;
  logic [CW-1:0] grant;
  logic [CW-1:0] idx;
  logic [CW-1:0] sel_ch;
  logic          any_valid;
  logic          load;
  logic          req;
  logic          capture;
  logic          sel_last;
  logic [W-1:0]  sel_data;
  int            base;

  assign load = !out_valid || out_ready;

  // Search starts at ptr in round-robin mode, at channel 0 in fixed-priority mode.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = '0;
    base      = (RR != 0) ? int'(ptr) : 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = CW'((base + k) % N_CH);
      if (!any_valid && in_valid[idx]) begin
        any_valid = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    sel_ch   = (state == LOCKED) ? lock_ch : grant;
    req      = (state == LOCKED) || any_valid;
    in_ready = '0;
    if (reset_n && load && req) in_ready[sel_ch] = 1'b1;
    capture  = reset_n && load && req && in_valid[sel_ch];
    sel_last = in_last[sel_ch];
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (CW'(i) == sel_ch) sel_data = in_data[i*W +: W];
    end
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_ch;
    case (state)
      IDLE: begin
        if (capture && !sel_last) begin
          state_nxt = LOCKED;
          lock_nxt  = grant;
        end
      end
      LOCKED: begin
        if (capture && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      lock_ch <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_nxt;
      if (RR != 0 && capture && sel_last) begin
        ptr <= (sel_ch == CW'(N_CH - 1)) ? '0 : sel_ch + CW'(1);
      end
    end
  end

  // Output register: a drain and a capture in the same cycle simply overwrite the beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= capture;
      if (capture) begin
        out_data <= sel_data;
        out_last <= sel_last;
        out_ch   <= sel_ch;
      end
    end
  end

endmodule
